// File: rtl/alu_pkg.sv
// Shared constants, flag layout and FSM state type for the ALU command issuer.
package alu_pkg;

  localparam int ALU_DATA_W = 8;
  localparam int ALU_OP_W   = 4;
  localparam int ALU_MAX_OP = 8;

  // Opcodes the ALU decodes; anything above OPC_8 is rejected by the issuer.
  localparam logic [3:0] OPC_0 = 4'b0000;
  localparam logic [3:0] OPC_1 = 4'b0001;
  localparam logic [3:0] OPC_2 = 4'b0010;
  localparam logic [3:0] OPC_3 = 4'b0011;
  localparam logic [3:0] OPC_4 = 4'b0100;
  localparam logic [3:0] OPC_5 = 4'b0101;
  localparam logic [3:0] OPC_6 = 4'b0110;
  localparam logic [3:0] OPC_7 = 4'b0111;
  localparam logic [3:0] OPC_8 = 4'b1000;

  // Bit positions inside rsp_flags = {err, overflow, zero, carry}.
  localparam int FLG_CARRY = 0;
  localparam int FLG_ZERO  = 1;
  localparam int FLG_OVF   = 2;
  localparam int FLG_ERR   = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO. Push is ignored when full, pop when empty;
// a simultaneous push and pop are both honoured. DEPTH must be a power of two.
module alu_cmd_fifo #(
  parameter int W     = 20,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // Next pointer/count; pointers wrap naturally modulo DEPTH.
  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) count_d = count_q + (AW+1)'(1);
    if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
  end

  // Pointer and occupancy registers; reset flushes the FIFO.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since occupancy gates reads.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// ALU command issuer: buffers commands, issues one at a time to the ALU,
// waits its fixed latency, and returns result/flags in command order.
// Optional macro ALU_ISSUE_STATS_EN adds saturating stat_issued/stat_errors.
// Handshakes: a transfer happens on a rising edge where valid & ready are both
// high; a held valid keeps its payload stable until ready is seen.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int DATA_W  = ALU_DATA_W,
  parameter int OP_W    = ALU_OP_W,
  parameter int MAX_OP  = ALU_MAX_OP,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [OP_W-1:0]   cmd_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [3:0]        rsp_flags,
  output logic              busy
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [15:0]       stat_issued,
  output logic [15:0]       stat_errors
`endif
);

  localparam int CMD_W = 2*DATA_W + OP_W;
  localparam int CNT_W = $clog2(ALU_LAT + 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic [3:0]        rsp_flags_q, rsp_flags_d;

  logic              fifo_full, fifo_empty, fifo_pop;
  logic [CMD_W-1:0]  fifo_rdata;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [DATA_W-1:0] head_a, head_b;
  logic [OP_W-1:0]   head_op;
  logic              head_illegal;

  // Ready is forced low while reset is asserted so nothing is accepted.
  assign cmd_ready  = rst & ~fifo_full;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign busy       = (state_q != ST_IDLE) | ~fifo_empty;

  assign {head_a, head_b, head_op} = fifo_rdata;
  assign head_illegal = int'(head_op) > MAX_OP;

  alu_cmd_fifo #(.W(CMD_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid & cmd_ready),
    .wdata ({cmd_a, cmd_b, cmd_op}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Next-state and datapath updates for the issue FSM.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    fifo_pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        // Head is consumed here; an illegal op never touches the ALU inputs.
        fifo_pop = 1'b1;
        if (head_illegal) begin
          rsp_result_d          = '0;
          rsp_flags_d           = '0;
          rsp_flags_d[FLG_ERR]  = 1'b1;
          state_d               = ST_RESP;
        end else begin
          alu_a_d  = head_a;
          alu_b_d  = head_b;
          alu_op_d = head_op;
          cnt_d    = CNT_W'(ALU_LAT);
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        rsp_result_d            = alu_result;
        rsp_flags_d             = '0;
        rsp_flags_d[FLG_CARRY]  = alu_carry;
        rsp_flags_d[FLG_ZERO]   = alu_zero;
        rsp_flags_d[FLG_OVF]    = alu_overflow;
        rsp_valid_d             = 1'b1;
        state_d                 = ST_RESP;
      end
      ST_RESP: begin
        // Error responses arrive here with valid low; raise it one cycle later.
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = fifo_empty ? ST_IDLE : ST_ISSUE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and output registers; reset discards any in-flight op.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
    end
  end

`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] stat_issued_q, stat_issued_d;
  logic [15:0] stat_errors_q, stat_errors_d;

  assign stat_issued = stat_issued_q;
  assign stat_errors = stat_errors_q;

  // Saturating counters of captured results and rejected opcodes.
  always_comb begin
    stat_issued_d = stat_issued_q;
    stat_errors_d = stat_errors_q;
    if (state_q == ST_CAPTURE && stat_issued_q != 16'hFFFF)
      stat_issued_d = stat_issued_q + 16'd1;
    if (state_q == ST_ISSUE && head_illegal && stat_errors_q != 16'hFFFF)
      stat_errors_d = stat_errors_q + 16'd1;
  end

  // Statistics registers, cleared on reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_issued_q <= '0;
      stat_errors_q <= '0;
    end else begin
      stat_issued_q <= stat_issued_d;
      stat_errors_q <= stat_errors_d;
    end
  end
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a 1-cycle registered XOR stub ALU.
module tb_alu_cmd_issuer;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_a, cmd_b;
  logic [3:0] cmd_op;
  logic [7:0] alu_a, alu_b;
  logic [3:0] alu_opcode;
  logic [7:0] alu_result;
  logic       alu_carry, alu_zero, alu_overflow;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic [3:0] rsp_flags;
  logic       busy;
`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] stat_issued, stat_errors;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  alu_cmd_issuer dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_a        (cmd_a),
    .cmd_b        (cmd_b),
    .cmd_op       (cmd_op),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_opcode   (alu_opcode),
    .alu_result   (alu_result),
    .alu_carry    (alu_carry),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_flags    (rsp_flags),
    .busy         (busy)
`ifdef ALU_ISSUE_STATS_EN
    ,
    .stat_issued  (stat_issued),
    .stat_errors  (stat_errors)
`endif
  );

  // Stub ALU: one registered stage, op0 = A^B, zero flag from result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      alu_result <= 8'h00;
      alu_zero   <= 1'b0;
    end else begin
      alu_result <= alu_a ^ alu_b;
      alu_zero   <= ((alu_a ^ alu_b) == 8'h00);
    end
  end
  assign alu_carry    = 1'b0;
  assign alu_overflow = 1'b0;

  // Scoreboard expected queue for ordered responses.
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: offer one command and return 1 time unit after its handshake edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    int guard;
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    guard     = 0;
    while (!cmd_ready && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) chk("send_timeout", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  // Wait (bounded) for rsp_valid; reports edges waited.
  task automatic wait_rsp(output int edges);
    edges = 0;
    while (!rsp_valid && edges < 60) begin
      tick();
      edges++;
    end
  endtask

  initial begin
    int n;
    logic seen;
    rst       = 1'b0;
    cmd_valid = 1'b1;
    cmd_a     = 8'hAA;
    cmd_b     = 8'hBB;
    cmd_op    = 4'd0;
    rsp_ready = 1'b0;

    // Reset with a command offered: nothing may be accepted.
    tick();
    chk("ready_in_reset", 32'(cmd_ready), 32'd0);
    tick();
    rst       = 1'b1;
    cmd_valid = 1'b0;
    #1;
    chk("ready_after_reset", 32'(cmd_ready), 32'd1);
    chk("rsp_valid_after_reset", 32'(rsp_valid), 32'd0);
    chk("busy_after_reset", 32'(busy), 32'd0);
    chk("alu_a_after_reset", 32'(alu_a), 32'd0);
    tick();
    chk("busy_no_push", 32'(busy), 32'd0);

    // Single op with latency count.
    rsp_ready = 1'b1;
    send(8'h66, 8'h55, 4'd0);
    wait_rsp(n);
    chk("single_latency", 32'(n), 32'd4);
    chk("single_valid", 32'(rsp_valid), 32'd1);
    chk("single_result", 32'(rsp_result), 32'h33);
    chk("single_flags", 32'(rsp_flags), 32'h0);
    tick();
    chk("single_consumed", 32'(rsp_valid), 32'd0);
    chk("single_idle", 32'(busy), 32'd0);

    // Backpressure: five commands fill FIFO plus one held response.
    rsp_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      send(8'(i), 8'h00, 4'd0);
      exp_q.push_back(8'(i));
    end
    chk("full_ready_low", 32'(cmd_ready), 32'd0);
    wait_rsp(n);
    chk("bp_first_result", 32'(rsp_result), 32'h01);
    repeat (5) tick();
    chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
    chk("bp_hold_result", 32'(rsp_result), 32'h01);
    chk("bp_still_full", 32'(cmd_ready), 32'd0);
    rsp_ready = 1'b1;
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      wait_rsp(n);
      chk("bp_order_valid", 32'(rsp_valid), 32'd1);
      chk("bp_order_result", 32'(rsp_result), 32'(e));
      tick();
    end
    repeat (2) tick();
    chk("bp_drained", 32'(busy), 32'd0);

    // Illegal opcode: error response, ALU inputs untouched.
    send(8'h77, 8'h12, 4'd9);
    wait_rsp(n);
    chk("illegal_latency", 32'(n), 32'd3);
    chk("illegal_result", 32'(rsp_result), 32'h00);
    chk("illegal_flags", 32'(rsp_flags), 32'h8);
    chk("illegal_alu_opcode", 32'(alu_opcode), 32'h0);
    chk("illegal_alu_a", 32'(alu_a), 32'h05);
    tick();

    // Legal op right after an error still completes.
    send(8'h0F, 8'hF0, 4'd0);
    wait_rsp(n);
    chk("post_illegal_latency", 32'(n), 32'd4);
    chk("post_illegal_result", 32'(rsp_result), 32'hFF);
    chk("post_illegal_flags", 32'(rsp_flags), 32'h0);
    tick();

    // Zero flag.
    send(8'h5A, 8'h5A, 4'd0);
    wait_rsp(n);
    chk("zero_result", 32'(rsp_result), 32'h00);
    chk("zero_flags", 32'(rsp_flags), 32'h2);
    tick();

    // Reset while the op is waiting on the ALU: no response may appear.
    send(8'h12, 8'h34, 4'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      seen = seen | rsp_valid;
      tick();
    end
    chk("midrst_no_rsp", 32'(seen), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(cmd_ready), 32'd1);
    chk("midrst_alu_a", 32'(alu_a), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
- Initiator for the 8-bit ALU. Accepts operand/opcode commands on a valid/ready port and buffers them in a small FIFO.
- Issues one command at a time to the ALU and waits the ALU's fixed latency, then captures result plus carry/zero/overflow.
- Returns the captured values on a valid/ready response port. Sits between a command source (CPU stub or test sequencer) and the alu block.

Parameters:
- DATA_W, 8, operand/result width.
- OP_W, 4, opcode width.
- MAX_OP, 8, highest legal opcode (ALU decodes 0..8).
- DEPTH, 4, command FIFO entries (power of two, >=2).
- ALU_LAT, 1, clock cycles from ALU input change to valid registered output (>=1).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-low; sampled on clk rising edge.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO not full.
- cmd_a  in  DATA_W  operand A.
- cmd_b  in  DATA_W  operand B.
- cmd_op  in  OP_W  opcode.
- alu_a  out  DATA_W  to ALU A.
- alu_b  out  DATA_W  to ALU B.
- alu_opcode  out  OP_W  to ALU opcode.
- alu_result  in  DATA_W  from ALU.
- alu_carry, alu_zero, alu_overflow  in  1 each  ALU flags.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  consumer accepts.
- rsp_result  out  DATA_W  captured result.
- rsp_flags  out  4  {err, overflow, zero, carry}.
- busy  out  1  FSM not IDLE or FIFO not empty.

Behaviour:
- Reset (rst=0 at edge): FIFO flushed, FSM=IDLE. All outputs 0 except cmd_ready=0 during reset and 1 on the first cycle after. In-flight op discarded, no response produced.
- cmd handshake = cmd_valid&cmd_ready. cmd_ready = !full. A push and a pop in the same cycle are both honoured. A push while full is impossible (ready low). Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- FSM: IDLE -> ISSUE when FIFO non-empty (pop head).
- ISSUE: register head onto alu_a/alu_b/alu_opcode. If op>MAX_OP, do not drive the ALU (alu_* keep previous values) and go to RESP with rsp_result=0, rsp_flags=4'b1000. Otherwise go to WAIT with wait counter=ALU_LAT.
- WAIT: decrement each cycle; at 0 go to CAPTURE.
- CAPTURE: sample alu_result and flags into rsp_* with err=0, set rsp_valid, go to RESP.
- RESP: hold rsp_* stable while rsp_valid&!rsp_ready. On handshake clear rsp_valid, then go to ISSUE if FIFO non-empty, else IDLE. No bubble cycle through IDLE.
- alu_* remain stable from ISSUE through CAPTURE.
- Latency, empty/idle block, rsp_ready=1: rsp_valid rises ALU_LAT+3 edges after the cmd handshake edge. Throughput is one op per ALU_LAT+3 cycles.
- An illegal opcode response appears 3 edges after handshake.
- Responses are returned strictly in command order.

Optional Feature:
- Macro ALU_ISSUE_STATS_EN.
- Defined: adds outputs stat_issued[15:0] and stat_errors[15:0]. stat_issued increments on each CAPTURE; stat_errors increments on each illegal-op ISSUE. Both saturate at 16'hFFFF and clear on reset.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package alu_pkg: DATA_W/OP_W defaults, MAX_OP, opcode localparams 4'b0000..4'b1000, flag-bit index constants (FLG_CARRY=0, FLG_ZERO=1, FLG_OVF=2, FLG_ERR=3), FSM state enum.
- One sub-module: alu_cmd_fifo (synchronous FIFO, DATA_W*2+OP_W wide, DEPTH entries, full/empty/count).

Test Plan:
- Bench uses a stub ALU (1-cycle registered, op0 = A^B, zero flag set when result=0, other flags 0).
- Reset: hold rst=0 for 2 cycles with cmd_valid=1 -> no push. After release cmd_ready=1, rsp_valid=0, busy=0.
- Single op: A=0x66, B=0x55, op=0 -> rsp_valid rises 4 edges after handshake. rsp_result=0x33, rsp_flags=4'b0000.
- Backpressure and full: push 5 cmds (A=1..5, B=0, op=0) with rsp_ready=0 -> cmd_ready drops after the 5th accepted (4 in FIFO, 1 held in RESP). The first rsp_result=0x01 stays stable. Release rsp_ready -> responses 1,2,3,4,5 in order.
- Illegal opcode: op=4'b1001 -> rsp_flags=4'b1000, rsp_result=0, alu_opcode unchanged. The next legal op still completes normally.
- Zero flag: A=0x5A, B=0x5A, op=0 -> rsp_result=0x00, rsp_flags=4'b0010.
- Mid-op reset: assert rst=0 during WAIT -> no rsp_valid ever for that op, FIFO empty, busy=0 after release.
